// File: rtl/lcd_scan.sv
// lcd_scan: pixel-clock timing generator and pixel-stream sink for a DE/HV-mode
// TFT panel (800x480 by default). Scans a line/frame raster, pulls one 24-bit
// pixel per active cycle over a valid/ready handshake, and drives registered
// panel pins.
//
// Ports:
//   CLK          pixel clock
//   RST_N        asynchronous active-low reset
//   ENABLE       1 = scan panel, 0 = idle / standby (counters held at origin)
//   PIX_DATA     upstream pixel {R,G,B}
//   PIX_VALID    PIX_DATA valid
//   PIX_READY    pixel consumed this cycle when PIX_VALID is also high (comb)
//   FRAME_START  one-cycle pulse at h=0, v=0 while enabled (comb)
//   UNDERRUN     sticky flag, set on an active cycle with no valid pixel
//   UNDERRUN_CLR clears UNDERRUN (a coincident set wins)
//   RGB/DEN/HSD/VSD/STBYB  registered panel outputs, one cycle after counters
//
// Optional feature: define LCD_SCAN_TESTPAT_EN to add the TESTPAT input, which
// replaces the pixel stream with 8 vertical colour bars and holds PIX_READY low.
module lcd_scan #(
  parameter int unsigned H_SYNC       = 1,
  parameter int unsigned H_BP         = 45,
  parameter int unsigned H_ACTIVE     = 800,
  parameter int unsigned H_FP         = 210,
  parameter int unsigned V_SYNC       = 1,
  parameter int unsigned V_BP         = 22,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned V_FP         = 22,
  parameter logic [23:0] UNDERRUN_RGB = 24'hFF00FF
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        ENABLE,
  input  logic [23:0] PIX_DATA,
  input  logic        PIX_VALID,
  output logic        PIX_READY,
  output logic        FRAME_START,
  output logic        UNDERRUN,
  input  logic        UNDERRUN_CLR,
`ifdef LCD_SCAN_TESTPAT_EN
  input  logic        TESTPAT,
`endif
  output logic [23:0] RGB,
  output logic        DEN,
  output logic        HSD,
  output logic        VSD,
  output logic        STBYB
);

  localparam logic [10:0] H_TOTAL_C   = 11'(H_SYNC + H_BP + H_ACTIVE + H_FP);
  localparam logic [10:0] V_TOTAL_C   = 11'(V_SYNC + V_BP + V_ACTIVE + V_FP);
  localparam logic [10:0] H_SYNC_END  = 11'(H_SYNC);
  localparam logic [10:0] V_SYNC_END  = 11'(V_SYNC);
  localparam logic [10:0] H_ACT_START = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_ACT_END   = 11'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [10:0] V_ACT_START = 11'(V_SYNC + V_BP);
  localparam logic [10:0] V_ACT_END   = 11'(V_SYNC + V_BP + V_ACTIVE);

  logic [10:0] h_cnt_r;
  logic [10:0] v_cnt_r;
  logic        h_last_s;
  logic        v_last_s;
  logic        active_s;
  logic        pat_s;
  logic        slot_s;
  logic        starve_s;
  logic [23:0] rgb_nxt_s;
  logic        underrun_r;

`ifdef LCD_SCAN_TESTPAT_EN
  localparam logic [10:0] BAR_W = 11'(H_ACTIVE / 8);

  logic [10:0] bar_idx_s;

  // Colour of each test bar, left to right.
  function automatic logic [23:0] bar_colour(input logic [10:0] idx);
    logic [23:0] c;
    case (idx)
      11'd0:   c = 24'hFFFFFF;
      11'd1:   c = 24'hFFFF00;
      11'd2:   c = 24'h00FFFF;
      11'd3:   c = 24'h00FF00;
      11'd4:   c = 24'hFF00FF;
      11'd5:   c = 24'hFF0000;
      11'd6:   c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

  // Bar index of the current active column.
  assign bar_idx_s = (h_cnt_r - H_ACT_START) / BAR_W;
  assign pat_s     = TESTPAT;
`else
  assign pat_s     = 1'b0;
`endif

  // Region decode and next-pixel selection from the counter registers.
  always_comb begin
    h_last_s = (h_cnt_r == (H_TOTAL_C - 11'd1));
    v_last_s = (v_cnt_r == (V_TOTAL_C - 11'd1));
    active_s = ENABLE
             && (h_cnt_r >= H_ACT_START) && (h_cnt_r < H_ACT_END)
             && (v_cnt_r >= V_ACT_START) && (v_cnt_r < V_ACT_END);
    // The pattern generator owns the active slots, so nothing is pulled
    // from upstream and starvation cannot be flagged.
    slot_s   = active_s && !pat_s;
    starve_s = slot_s && !PIX_VALID;
    rgb_nxt_s = 24'h000000;
    if (!active_s) begin
      rgb_nxt_s = 24'h000000;
    end else if (pat_s) begin
`ifdef LCD_SCAN_TESTPAT_EN
      rgb_nxt_s = bar_colour(bar_idx_s);
`else
      rgb_nxt_s = 24'h000000;
`endif
    end else if (PIX_VALID) begin
      rgb_nxt_s = PIX_DATA;
    end else begin
      rgb_nxt_s = UNDERRUN_RGB;
    end
  end

  assign PIX_READY   = slot_s;
  assign FRAME_START = ENABLE && (h_cnt_r == 11'd0) && (v_cnt_r == 11'd0);
  assign UNDERRUN    = underrun_r;

  // Raster counters; held at the origin while disabled so a re-enable
  // restarts a fresh frame rather than finishing a partial line.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      h_cnt_r <= 11'd0;
      v_cnt_r <= 11'd0;
    end else if (!ENABLE) begin
      h_cnt_r <= 11'd0;
      v_cnt_r <= 11'd0;
    end else if (h_last_s) begin
      h_cnt_r <= 11'd0;
      v_cnt_r <= v_last_s ? 11'd0 : (v_cnt_r + 11'd1);
    end else begin
      h_cnt_r <= h_cnt_r + 11'd1;
    end
  end

  // Registered panel pins, one cycle behind the counters.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      RGB   <= 24'h000000;
      DEN   <= 1'b0;
      HSD   <= 1'b1;
      VSD   <= 1'b1;
      STBYB <= 1'b0;
    end else if (!ENABLE) begin
      RGB   <= 24'h000000;
      DEN   <= 1'b0;
      HSD   <= 1'b1;
      VSD   <= 1'b1;
      STBYB <= 1'b0;
    end else begin
      RGB   <= rgb_nxt_s;
      DEN   <= active_s;
      HSD   <= !(h_cnt_r < H_SYNC_END);
      VSD   <= !(v_cnt_r < V_SYNC_END);
      STBYB <= 1'b1;
    end
  end

  // Sticky starvation flag; a set in the same cycle as a clear takes priority.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      underrun_r <= 1'b0;
    end else if (starve_s) begin
      underrun_r <= 1'b1;
    end else if (UNDERRUN_CLR) begin
      underrun_r <= 1'b0;
    end else begin
      underrun_r <= underrun_r;
    end
  end

endmodule

// File: tb/tb_lcd_scan.sv
// Self-checking bench for lcd_scan using a shrunken raster so several frames
// fit in a short run. A raster model predicts comb and registered outputs;
// expected RGB values go into a scoreboard queue when a slot is driven and are
// popped when the DUT presents the pixel one cycle later.
module tb_lcd_scan;
  localparam int HS = 2, HBP = 3, HA = 16, HFP = 4;
  localparam int VS = 1, VBP = 2, VA = 6, VFP = 2;
  localparam int HT = HS + HBP + HA + HFP;   // 25
  localparam int VT = VS + VBP + VA + VFP;   // 11
  localparam logic [23:0] URGB = 24'hFF00FF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        vld = 1'b0;
  logic        clr = 1'b0;
  logic        tp = 1'b0;
  logic [23:0] data = 24'h0;
  logic        pix_ready, frame_start, underrun, den, hsd, vsd, stbyb;
  logic [23:0] rgb;

  int total = 0;
  int bad = 0;
  int m_h = 0;
  int m_v = 0;
  logic m_und = 1'b0;
  logic [23:0] sb[$];
  logic [23:0] next_pix = 24'h0;
  int n_den = 0, n_fs = 0, n_hsd_low = 0, n_acc = 0;
  logic last_fs = 1'b0;
  int last_x = -1;

  always #5 clk = ~clk;

  lcd_scan #(
    .H_SYNC(HS), .H_BP(HBP), .H_ACTIVE(HA), .H_FP(HFP),
    .V_SYNC(VS), .V_BP(VBP), .V_ACTIVE(VA), .V_FP(VFP),
    .UNDERRUN_RGB(URGB)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .ENABLE(en),
    .PIX_DATA(data), .PIX_VALID(vld), .PIX_READY(pix_ready),
    .FRAME_START(frame_start), .UNDERRUN(underrun), .UNDERRUN_CLR(clr),
`ifdef LCD_SCAN_TESTPAT_EN
    .TESTPAT(tp),
`endif
    .RGB(rgb), .DEN(den), .HSD(hsd), .VSD(vsd), .STBYB(stbyb)
  );

  function automatic logic [23:0] bar(input int x);
    case (x / (HA / 8))
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic m_active(input logic e);
    return e && (m_h >= HS + HBP) && (m_h < HS + HBP + HA)
             && (m_v >= VS + VBP) && (m_v < VS + VBP + VA);
  endfunction

  // One pixel clock: drive inputs, check comb outputs mid-cycle, advance the
  // model, then check registered outputs and the scoreboard after the edge.
  task automatic tick(input logic e, input logic v, input logic c);
    logic exp_act, exp_fs, exp_rdy, exp_hsd, exp_vsd;
    logic [23:0] exp_rgb;
    en = e; vld = v; clr = c;
    exp_fs = e && (m_h == 0) && (m_v == 0);
    if (exp_fs) next_pix = 24'h0;       // reader rewinds to framebuffer base
    data = next_pix;
    exp_act = m_active(e);
    exp_rdy = exp_act && !tp;
    last_x = exp_act ? (m_h - (HS + HBP)) : -1;
    @(negedge clk);
    total += 2;
    if (pix_ready !== exp_rdy) begin
      bad++; $display("FAIL pix_ready h=%0d v=%0d: got %b want %b", m_h, m_v, pix_ready, exp_rdy);
    end
    if (frame_start !== exp_fs) begin
      bad++; $display("FAIL frame_start h=%0d v=%0d: got %b want %b", m_h, m_v, frame_start, exp_fs);
    end
    last_fs = frame_start;
    if (frame_start === 1'b1) n_fs++;
    if (exp_act) begin
      if (tp) sb.push_back(bar(m_h - (HS + HBP)));
      else if (v) begin sb.push_back(next_pix); next_pix++; n_acc++; end
      else sb.push_back(URGB);
    end
    exp_hsd = !(e && (m_h < HS));
    exp_vsd = !(e && (m_v < VS));
    if (exp_rdy && !v) m_und = 1'b1;
    else if (c) m_und = 1'b0;
    if (!e) begin m_h = 0; m_v = 0; end
    else if (m_h == HT - 1) begin m_h = 0; m_v = (m_v == VT - 1) ? 0 : m_v + 1; end
    else m_h++;
    @(posedge clk); #1;
    total += 6;
    if (den !== exp_act) begin
      bad++; $display("FAIL den: got %b want %b", den, exp_act);
    end
    if (hsd !== exp_hsd) begin
      bad++; $display("FAIL hsd: got %b want %b", hsd, exp_hsd);
    end
    if (vsd !== exp_vsd) begin
      bad++; $display("FAIL vsd: got %b want %b", vsd, exp_vsd);
    end
    if (stbyb !== e) begin
      bad++; $display("FAIL stbyb: got %b want %b", stbyb, e);
    end
    if (underrun !== m_und) begin
      bad++; $display("FAIL underrun: got %b want %b", underrun, m_und);
    end
    if (exp_act) begin
      if (sb.size() == 0) begin
        bad++; $display("FAIL rgb_scoreboard: got %h want queued pixel (queue empty)", rgb);
      end else begin
        exp_rgb = sb.pop_front();
        if (rgb !== exp_rgb) begin
          bad++; $display("FAIL rgb: got %h want %h", rgb, exp_rgb);
        end
      end
    end else if (rgb !== 24'h0) begin
      bad++; $display("FAIL rgb_idle: got %h want 000000", rgb);
    end
    if (den === 1'b1) n_den++;
    if (hsd === 1'b0) n_hsd_low++;
  endtask

  task automatic seek(input int h, input int v);
    for (int i = 0; i < HT * VT && !(m_h == h && m_v == v); i++) tick(1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0);
    total += 3;
    if (rgb !== 24'h0 || den !== 1'b0) begin
      bad++; $display("FAIL reset_rgb_den: got %h/%b want 000000/0", rgb, den);
    end
    if (hsd !== 1'b1 || vsd !== 1'b1 || stbyb !== 1'b0) begin
      bad++; $display("FAIL reset_sync: got hsd=%b vsd=%b stbyb=%b want 1/1/0", hsd, vsd, stbyb);
    end
    if (underrun !== 1'b0 || frame_start !== 1'b0) begin
      bad++; $display("FAIL reset_flags: got und=%b fs=%b want 0/0", underrun, frame_start);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_frame();
    n_den = 0; n_fs = 0; n_hsd_low = 0; n_acc = 0;
    for (int i = 0; i < 2 * HT * VT; i++) tick(1'b1, 1'b1, 1'b0);
    total += 4;
    if (n_fs !== 2) begin
      bad++; $display("FAIL frame_start_count: got %0d want 2", n_fs);
    end
    if (n_den !== 2 * HA * VA) begin
      bad++; $display("FAIL den_count: got %0d want %0d", n_den, 2 * HA * VA);
    end
    if (n_acc !== 2 * HA * VA) begin
      bad++; $display("FAIL accept_count: got %0d want %0d", n_acc, 2 * HA * VA);
    end
    if (n_hsd_low !== 2 * VT * HS) begin
      bad++; $display("FAIL hsd_low_count: got %0d want %0d", n_hsd_low, 2 * VT * HS);
    end
  endtask

  task automatic test_underrun();
    seek(HS + HBP + 3, VS + VBP + 2);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0);
    total++;
    if (underrun !== 1'b1) begin
      bad++; $display("FAIL underrun_set: got %b want 1", underrun);
    end
    n_hsd_low = 0;
    for (int i = 0; i < HT; i++) tick(1'b1, 1'b1, 1'b0);
    total += 2;
    if (underrun !== 1'b1) begin
      bad++; $display("FAIL underrun_sticky: got %b want 1", underrun);
    end
    if (n_hsd_low !== HS) begin
      bad++; $display("FAIL underrun_line_timing: got %0d want %0d", n_hsd_low, HS);
    end
  endtask

  task automatic test_clear();
    for (int i = 0; i < HT * VT && !m_active(1'b1); i++) tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b1);
    total++;
    if (underrun !== 1'b1) begin
      bad++; $display("FAIL clear_vs_set: got %b want 1", underrun);
    end
    for (int i = 0; i < HT * VT && m_active(1'b1); i++) tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b1);
    total++;
    if (underrun !== 1'b0) begin
      bad++; $display("FAIL clear: got %b want 0", underrun);
    end
  endtask

  task automatic test_disable();
    seek(HS + HBP + 5, VS + VBP + 3);
    tick(1'b0, 1'b1, 1'b0);
    total++;
    if (den !== 1'b0 || hsd !== 1'b1 || vsd !== 1'b1 || stbyb !== 1'b0) begin
      bad++; $display("FAIL disable_idle: got den=%b hsd=%b vsd=%b stbyb=%b want 0/1/1/0",
                      den, hsd, vsd, stbyb);
    end
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    total++;
    if (last_fs !== 1'b1) begin
      bad++; $display("FAIL reenable_frame_start: got %b want 1", last_fs);
    end
    // A full frame after restart: the next FRAME_START lands exactly one period later.
    n_fs = 0;
    for (int i = 0; i < HT * VT; i++) tick(1'b1, 1'b1, 1'b0);
    total++;
    if (n_fs !== 1 || last_fs !== 1'b1) begin
      bad++; $display("FAIL restart_period: got count=%0d last=%b want 1/1", n_fs, last_fs);
    end
  endtask

`ifdef LCD_SCAN_TESTPAT_EN
  task automatic test_testpat();
    tp = 1'b1;
    for (int i = 0; i < HT * VT; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      if (last_x == 0 || last_x == HA / 8 || last_x == HA - 1) begin
        total++;
        if (rgb !== ((last_x == 0) ? 24'hFFFFFF : (last_x == HA / 8) ? 24'hFFFF00 : 24'h000000)) begin
          bad++; $display("FAIL testpat_x%0d: got %h", last_x, rgb);
        end
      end
    end
    tp = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_frame();
    test_underrun();
    test_clear();
    test_disable();
`ifdef LCD_SCAN_TESTPAT_EN
    test_testpat();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
